player_input_controller: RTL and testbench

Converts one player's raw push-button inputs into the per-tick movement commands that the physics engine consumes (movingLeft, movingRight, isJumping), plus an attack command with active/cooldown timing. Buttons are synchronised, debounced and edge-detected on the fast system clock. Jump and attack requests are latched and presented on the game tick, so no press is lost between the 20 Hz physics updates. One instance sits between the board buttons and each player's physics engine.

---
 rtl/player_input_controller.sv | 208 ++++++++++++++++++++
 tb/tb_player_input_controller.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_input_controller.sv
`default_nettype none
// ============================================================================
//  Module      : player_input_controller
//  Description : Turns one player's raw push buttons into per-tick movement,
//                jump and attack commands for the physics engine. Buttons are
//                synchronised, debounced and edge-detected on clk. Jump and
//                attack presses are latched until the next game tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_input_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ATTACK_TICKS    = 3,
    parameter int COOLDOWN_TICKS  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic enable,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_jump,
    input  logic btn_attack,
    output logic movingLeft,
    output logic movingRight,
    output logic isJumping,
    output logic isAttacking
);

    // Button index map shared by the synchroniser and debouncers
    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_JUMP   = 2;
    localparam int BTN_ATTACK = 3;
    localparam int NUM_BTN    = 4;

    localparam int DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int MAX_TICKS = (ATTACK_TICKS > COOLDOWN_TICKS) ? ATTACK_TICKS : COOLDOWN_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_COOLDOWN = 2'd2
    } atk_state_t;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] deb;
    logic               deb_jump_prev;
    logic               deb_atk_prev;
    logic               jump_rise;
    logic               atk_rise;
    logic               jump_pending;
    logic               atk_pending;
    atk_state_t         state;
    logic [CNT_W-1:0]   atk_cnt;

    assign raw = {btn_attack, btn_jump, btn_right, btn_left};

    // Two-flop synchroniser for every raw button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // One debouncer per button: the synchronised level must disagree with the
    // debounced level for DEBOUNCE_CYCLES consecutive clocks before it is taken
    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_debounce
            logic [DEB_W-1:0] cnt;
            logic             deb_q;

            // Count disagreement cycles; flip the debounced level on the last one
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt   <= '0;
                    deb_q <= 1'b0;
                end else if (sync2[i] != deb_q) begin
                    if (cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb_q <= sync2[i];
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + DEB_W'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end

            assign deb[i] = deb_q;
        end
    endgenerate

    // Previous debounced levels for rising-edge detection of jump and attack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_jump_prev <= 1'b0;
            deb_atk_prev  <= 1'b0;
        end else begin
            deb_jump_prev <= deb[BTN_JUMP];
            deb_atk_prev  <= deb[BTN_ATTACK];
        end
    end

    assign jump_rise = deb[BTN_JUMP]   & ~deb_jump_prev;
    assign atk_rise  = deb[BTN_ATTACK] & ~deb_atk_prev;

    // Movement commands; opposing buttons cancel and an active attack freezes movement
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            movingLeft  <= 1'b0;
            movingRight <= 1'b0;
        end else begin
            movingLeft  <= enable & deb[BTN_LEFT]  & ~deb[BTN_RIGHT] & (state != ST_ACTIVE);
            movingRight <= enable & deb[BTN_RIGHT] & ~deb[BTN_LEFT]  & (state != ST_ACTIVE);
        end
    end

    // Jump latch: a press is held until the next tick, then shown for one tick interval.
    // An edge arriving together with a tick is kept for the following tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jump_pending <= 1'b0;
            isJumping    <= 1'b0;
        end else if (!enable) begin
            jump_pending <= 1'b0;
            isJumping    <= 1'b0;
        end else if (tick) begin
            isJumping    <= jump_pending;
            jump_pending <= jump_rise;
        end else if (jump_rise) begin
            jump_pending <= 1'b1;
        end
    end

    // Attack FSM: IDLE -> ACTIVE for ATTACK_TICKS ticks -> COOLDOWN -> IDLE.
    // Presses are only latched while IDLE; transitions happen on ticks only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            atk_cnt     <= '0;
            atk_pending <= 1'b0;
            isAttacking <= 1'b0;
        end else if (!enable) begin
            state       <= ST_IDLE;
            atk_cnt     <= '0;
            atk_pending <= 1'b0;
            isAttacking <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick && atk_pending) begin
                        state       <= ST_ACTIVE;
                        atk_cnt     <= CNT_W'(ATTACK_TICKS - 1);
                        atk_pending <= 1'b0;
                        isAttacking <= 1'b1;
                    end else begin
                        if (atk_rise) begin
                            atk_pending <= 1'b1;
                        end
                        isAttacking <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    atk_pending <= 1'b0;
                    if (tick) begin
                        if (atk_cnt == '0) begin
                            isAttacking <= 1'b0;
                            if (COOLDOWN_TICKS == 0) begin
                                state <= ST_IDLE;
                            end else begin
                                state   <= ST_COOLDOWN;
                                atk_cnt <= CNT_W'(COOLDOWN_TICKS - 1);
                            end
                        end else begin
                            atk_cnt <= atk_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_COOLDOWN: begin
                    atk_pending <= 1'b0;
                    isAttacking <= 1'b0;
                    if (tick) begin
                        if (atk_cnt == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            atk_cnt <= atk_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    atk_cnt     <= '0;
                    atk_pending <= 1'b0;
                    isAttacking <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_player_input_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_input_controller
//  Description : Directed self-checking bench for player_input_controller
//                (DEBOUNCE_CYCLES=4, ATTACK_TICKS=3, COOLDOWN_TICKS=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_input_controller;

    logic clk = 1'b0;
    logic reset;
    logic tick;
    logic enable;
    logic btn_left;
    logic btn_right;
    logic btn_jump;
    logic btn_attack;
    logic movingLeft;
    logic movingRight;
    logic isJumping;
    logic isAttacking;

    int checks   = 0;
    int failures = 0;

    player_input_controller #(
        .DEBOUNCE_CYCLES (4),
        .ATTACK_TICKS    (3),
        .COOLDOWN_TICKS  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .enable      (enable),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_jump    (btn_jump),
        .btn_attack  (btn_attack),
        .movingLeft  (movingLeft),
        .movingRight (movingRight),
        .isJumping   (isJumping),
        .isAttacking (isAttacking)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-clock game tick
    task automatic pulse_tick;
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] outs;
        reset = 1'b0; tick = 1'b0; enable = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; btn_attack = 1'b0;
        step(3);
        outs = {movingLeft, movingRight, isJumping, isAttacking};
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 0000", outs);
        end
        reset = 1'b1;
        step(3);
        outs = {movingLeft, movingRight, isJumping, isAttacking};
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL after_reset_idle: got %b want 0000", outs);
        end
    endtask

    task automatic test_move_left;
        btn_left = 1'b1;       // first sampled at the next edge (k)
        step(6);               // edge k+5
        checks++;
        if (movingLeft !== 1'b0) begin
            failures++;
            $display("FAIL left_early: got %b want 0", movingLeft);
        end
        step(1);               // edge k+6
        checks++;
        if (movingLeft !== 1'b1) begin
            failures++;
            $display("FAIL left_rise: got %b want 1", movingLeft);
        end
        btn_left = 1'b0;
        step(6);
        checks++;
        if (movingLeft !== 1'b1) begin
            failures++;
            $display("FAIL left_release_early: got %b want 1", movingLeft);
        end
        step(1);
        checks++;
        if (movingLeft !== 1'b0) begin
            failures++;
            $display("FAIL left_fall: got %b want 0", movingLeft);
        end
    endtask

    task automatic test_glitch_and_both;
        logic seen;
        seen = 1'b0;
        btn_right = 1'b1;
        step(3);
        btn_right = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            seen = seen | movingRight;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL right_glitch: got movingRight=%b want 0", seen);
        end
        seen = 1'b0;
        btn_left = 1'b1; btn_right = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(1);
            seen = seen | movingLeft | movingRight;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL both_held: got %b want 0", seen);
        end
        btn_left = 1'b0; btn_right = 1'b0;
        step(10);
    endtask

    task automatic test_jump;
        logic seen;
        btn_jump = 1'b1;
        step(8);               // debounced and latched, no tick yet
        checks++;
        if (isJumping !== 1'b0) begin
            failures++;
            $display("FAIL jump_before_tick: got %b want 0", isJumping);
        end
        pulse_tick();
        checks++;
        if (isJumping !== 1'b1) begin
            failures++;
            $display("FAIL jump_rise: got %b want 1", isJumping);
        end
        step(5);
        checks++;
        if (isJumping !== 1'b1) begin
            failures++;
            $display("FAIL jump_hold_interval: got %b want 1", isJumping);
        end
        pulse_tick();
        checks++;
        if (isJumping !== 1'b0) begin
            failures++;
            $display("FAIL jump_fall: got %b want 0", isJumping);
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(3);
            pulse_tick();
            seen = seen | isJumping;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL jump_no_retrigger: got %b want 0", seen);
        end
        btn_jump = 1'b0;
        step(8);
        btn_jump = 1'b1;
        step(8);
        pulse_tick();
        checks++;
        if (isJumping !== 1'b1) begin
            failures++;
            $display("FAIL jump_second_rise: got %b want 1", isJumping);
        end
        pulse_tick();
        checks++;
        if (isJumping !== 1'b0) begin
            failures++;
            $display("FAIL jump_second_fall: got %b want 0", isJumping);
        end
        btn_jump = 1'b0;
        step(8);
    endtask

    task automatic test_jump_coincident;
        btn_jump = 1'b1;       // debounced level flips at edge k+5
        step(6);
        tick = 1'b1;           // tick on the edge that sees the rising edge
        step(1);
        tick = 1'b0;
        checks++;
        if (isJumping !== 1'b0) begin
            failures++;
            $display("FAIL coincident_first_tick: got %b want 0", isJumping);
        end
        step(3);
        pulse_tick();
        checks++;
        if (isJumping !== 1'b1) begin
            failures++;
            $display("FAIL coincident_next_tick: got %b want 1", isJumping);
        end
        pulse_tick();
        checks++;
        if (isJumping !== 1'b0) begin
            failures++;
            $display("FAIL coincident_fall: got %b want 0", isJumping);
        end
        btn_jump = 1'b0;
        step(8);
    endtask

    task automatic test_attack;
        logic seen;
        btn_left = 1'b1;
        step(8);
        checks++;
        if (movingLeft !== 1'b1) begin
            failures++;
            $display("FAIL attack_pre_move: got %b want 1", movingLeft);
        end
        btn_attack = 1'b1;
        step(8);
        pulse_tick();          // accepting tick T0
        checks++;
        if (isAttacking !== 1'b1) begin
            failures++;
            $display("FAIL attack_rise: got %b want 1", isAttacking);
        end
        btn_attack = 1'b0;
        step(1);
        checks++;
        if (movingLeft !== 1'b0) begin
            failures++;
            $display("FAIL attack_move_suppress: got %b want 0", movingLeft);
        end
        step(8);
        pulse_tick();          // T1
        checks++;
        if (isAttacking !== 1'b1) begin
            failures++;
            $display("FAIL attack_t1: got %b want 1", isAttacking);
        end
        step(4);
        pulse_tick();          // T2
        checks++;
        if (isAttacking !== 1'b1) begin
            failures++;
            $display("FAIL attack_t2: got %b want 1", isAttacking);
        end
        step(4);
        pulse_tick();          // T3: into cooldown
        checks++;
        if (isAttacking !== 1'b0) begin
            failures++;
            $display("FAIL attack_end: got %b want 0", isAttacking);
        end
        step(1);
        checks++;
        if (movingLeft !== 1'b1) begin
            failures++;
            $display("FAIL attack_move_resume: got %b want 1", movingLeft);
        end
        btn_attack = 1'b1;     // press during cooldown, must be discarded
        step(8);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse_tick();      // T4..T7
            step(2);
            seen = seen | isAttacking;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL cooldown_press_ignored: got %b want 0", seen);
        end
        btn_attack = 1'b0;
        step(8);
        btn_attack = 1'b1;
        step(8);
        pulse_tick();
        checks++;
        if (isAttacking !== 1'b1) begin
            failures++;
            $display("FAIL attack_second: got %b want 1", isAttacking);
        end
        step(2);
    endtask

    task automatic test_enable_and_reset;
        logic [3:0] outs;
        enable = 1'b0;         // attack currently active, btn_left held
        step(1);
        outs = {movingLeft, movingRight, isJumping, isAttacking};
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL enable_low_outputs: got %b want 0000", outs);
        end
        btn_attack = 1'b0;
        step(8);
        enable = 1'b1;
        step(2);
        checks++;
        if (movingLeft !== 1'b1) begin
            failures++;
            $display("FAIL enable_return_move: got %b want 1", movingLeft);
        end
        pulse_tick();
        checks++;
        if (isAttacking !== 1'b0) begin
            failures++;
            $display("FAIL enable_clears_attack: got %b want 0", isAttacking);
        end
        btn_jump = 1'b1;
        step(8);
        pulse_tick();
        checks++;
        if (isJumping !== 1'b1) begin
            failures++;
            $display("FAIL mid_jump_setup: got %b want 1", isJumping);
        end
        btn_jump = 1'b0;
        step(8);
        btn_jump = 1'b1;       // second jump left pending
        step(8);
        btn_attack = 1'b1;     // attack left pending
        step(8);
        reset = 1'b0;
        #2;
        outs = {movingLeft, movingRight, isJumping, isAttacking};
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset_outputs: got %b want 0000", outs);
        end
        btn_left = 1'b0; btn_jump = 1'b0; btn_attack = 1'b0;
        step(2);
        reset = 1'b1;
        step(2);
        pulse_tick();
        step(1);
        outs = {movingLeft, movingRight, isJumping, isAttacking};
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL after_reset_no_pending: got %b want 0000", outs);
        end
    endtask

    initial begin
        test_reset();
        test_move_left();
        test_glitch_and_both();
        test_jump();
        test_jump_coincident();
        test_attack();
        test_enable_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
